// File: rtl/mdu.sv
// Multiply/divide unit with HI/LO registers: mult/div results are computed at issue,
// held in shadow registers, and committed to HI/LO after a fixed busy period.
module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  op,
    input  logic        start,
    input  logic        req,
    output logic        busy,
    output logic [31:0] out
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    typedef enum logic {IDLE, BUSY} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   hi_q, hi_d, lo_q, lo_d;
    logic [31:0]   shHi_q, shHi_d, shLo_q, shLo_d;

    logic        isMulDiv, isMult, issue, finishing;
    logic [63:0] prodS, prodU;
    logic [31:0] absA, absB, safeB, safeAbsB;
    logic [31:0] quoU, remU, quoMag, remMag, quoS, remS;
    logic [31:0] resHi, resLo;

    assign isMult    = (op == OP_MULT) || (op == OP_MULTU);
    assign isMulDiv  = isMult || (op == OP_DIV) || (op == OP_DIVU);
    assign issue     = start && !req && (state_q == IDLE) &&
                       (isMulDiv || (op == OP_MTHI) || (op == OP_MTLO));
    assign finishing = (state_q == BUSY) && (cnt_q == CW'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            shHi_q  <= '0;
            shLo_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            shHi_q  <= shHi_d;
            shLo_q  <= shLo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (issue && isMulDiv) begin
                    state_d = BUSY;
                    cnt_d   = isMult ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                end
            end
            BUSY: begin
                if (finishing) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Signed division works on magnitudes; the divisor is forced nonzero so a
    // divide-by-zero never produces X, and its result is discarded anyway.
    always_comb begin
        prodU    = {32'd0, A} * {32'd0, B};
        prodS    = {{32{A[31]}}, A} * {{32{B[31]}}, B};
        absA     = A[31] ? (~A + 32'd1) : A;
        absB     = B[31] ? (~B + 32'd1) : B;
        safeB    = (B == 32'd0) ? 32'd1 : B;
        safeAbsB = (B == 32'd0) ? 32'd1 : absB;
        quoU     = A / safeB;
        remU     = A % safeB;
        quoMag   = absA / safeAbsB;
        remMag   = absA % safeAbsB;
        quoS     = (A[31] ^ B[31]) ? (~quoMag + 32'd1) : quoMag;
        remS     = A[31] ? (~remMag + 32'd1) : remMag;

        resHi = hi_q;
        resLo = lo_q;
        case (op)
            OP_MULT:  {resHi, resLo} = prodS;
            OP_MULTU: {resHi, resLo} = prodU;
            OP_DIV:   if (B != 32'd0) begin resHi = remS; resLo = quoS; end
            OP_DIVU:  if (B != 32'd0) begin resHi = remU; resLo = quoU; end
            default:  ;
        endcase
    end

    always_comb begin
        hi_d   = hi_q;
        lo_d   = lo_q;
        shHi_d = shHi_q;
        shLo_d = shLo_q;
        if (issue) begin
            if (op == OP_MTHI) begin
                hi_d = A;
            end else if (op == OP_MTLO) begin
                lo_d = A;
            end else begin
                shHi_d = resHi;
                shLo_d = resLo;
            end
        end
        if (finishing) begin
            hi_d = shHi_q;
            lo_d = shLo_q;
        end
    end

    always_comb begin
        busy = (state_q == BUSY);
        case (op)
            OP_MFHI: out = hi_q;
            OP_MFLO: out = lo_q;
            default: out = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed scenarios plus randomized ops checked
// against an arithmetic HI/LO model.
module tb_mdu;

    localparam int MC = 5;
    localparam int DC = 10;

    localparam logic [3:0] NONE  = 4'd0;
    localparam logic [3:0] MULT  = 4'd1;
    localparam logic [3:0] MULTU = 4'd2;
    localparam logic [3:0] DIV   = 4'd3;
    localparam logic [3:0] DIVU  = 4'd4;
    localparam logic [3:0] MTHI  = 4'd5;
    localparam logic [3:0] MTLO  = 4'd6;
    localparam logic [3:0] MFHI  = 4'd7;
    localparam logic [3:0] MFLO  = 4'd8;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] A, B;
    logic [3:0]  op;
    logic        start, req;
    logic        busy;
    logic [31:0] out;

    int checks = 0;
    int errors = 0;
    logic [31:0] hiM, loM;

    mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .A(A), .B(B), .op(op),
        .start(start), .req(req), .busy(busy), .out(out)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: HI/LO as plain 64-bit arithmetic, plus the expected busy length.
    task automatic modelOp(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                           output int cyc);
        longint sa, sb, p, q, r;
        longint unsigned ua, ub, pu;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        cyc = 0;
        case (o)
            MULT:  begin p = sa * sb; hiM = p[63:32]; loM = p[31:0]; cyc = MC; end
            MULTU: begin pu = ua * ub; hiM = pu[63:32]; loM = pu[31:0]; cyc = MC; end
            DIV: begin
                cyc = DC;
                if (b != 0) begin q = sa / sb; r = sa % sb; loM = q[31:0]; hiM = r[31:0]; end
            end
            DIVU: begin
                cyc = DC;
                if (b != 0) begin pu = ua / ub; loM = pu[31:0]; pu = ua % ub; hiM = pu[31:0]; end
            end
            MTHI: hiM = a;
            MTLO: loM = a;
            default: ;
        endcase
    endtask

    // Issues o, counts busy cycles (bounded), optionally drives one interfering
    // input pattern on busy cycle intrCycle, then reads HI/LO via MFHI/MFLO.
    task automatic runOp(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         input int intrCycle, input logic [3:0] intrOp,
                         input logic [31:0] intrA, input logic intrReq,
                         output int cyc, output logic [31:0] hiR, output logic [31:0] loR);
        op = o; A = a; B = b; start = 1'b1; req = 1'b0;
        step();
        start = 1'b0; op = NONE;
        cyc = 0;
        while (busy === 1'b1 && cyc < 100) begin
            cyc++;
            if (cyc == intrCycle) begin
                start = (intrOp != NONE); op = intrOp; A = intrA; req = intrReq;
            end else begin
                start = 1'b0; op = NONE; req = 1'b0;
            end
            step();
        end
        start = 1'b0; req = 1'b0;
        op = MFHI; #1 hiR = out;
        op = MFLO; #1 loR = out;
        op = NONE;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; req = 1'b0; op = NONE; A = '0; B = '0;
        step(); step();
        reset = 1'b0;
        hiM = '0; loM = '0;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %0b want 0", busy); end
        for (int i = 0; i < 16; i++) begin
            op = 4'(i);
            #0.1;
            checks++;
            if (out !== 32'd0) begin errors++; $display("[TB] FAIL reset_out op=%0d got %h want 0", i, out); end
        end
        op = NONE;
    endtask

    task automatic test_mult();
        int cyc, ec; logic [31:0] h, l;
        runOp(MULT, 32'hFFFFFFFE, 32'd3, 0, NONE, '0, 1'b0, cyc, h, l);
        modelOp(MULT, 32'hFFFFFFFE, 32'd3, ec);
        checks += 3;
        if (cyc !== 5) begin errors++; $display("[TB] FAIL mult_busy got %0d want 5", cyc); end
        if (h !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL mult_hi got %h want ffffffff", h); end
        if (l !== 32'hFFFFFFFA) begin errors++; $display("[TB] FAIL mult_lo got %h want fffffffa", l); end
    endtask

    task automatic test_div();
        int cyc, ec; logic [31:0] h, l;
        runOp(DIV, 32'hFFFFFFF9, 32'd2, 0, NONE, '0, 1'b0, cyc, h, l);
        modelOp(DIV, 32'hFFFFFFF9, 32'd2, ec);
        checks += 3;
        if (cyc !== 10) begin errors++; $display("[TB] FAIL div_busy got %0d want 10", cyc); end
        if (l !== 32'hFFFFFFFD) begin errors++; $display("[TB] FAIL div_lo got %h want fffffffd", l); end
        if (h !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL div_hi got %h want ffffffff", h); end
        runOp(DIVU, 32'hFFFFFFF9, 32'd2, 0, NONE, '0, 1'b0, cyc, h, l);
        modelOp(DIVU, 32'hFFFFFFF9, 32'd2, ec);
        checks += 3;
        if (cyc !== 10) begin errors++; $display("[TB] FAIL divu_busy got %0d want 10", cyc); end
        if (l !== 32'h7FFFFFFC) begin errors++; $display("[TB] FAIL divu_lo got %h want 7ffffffc", l); end
        if (h !== 32'd1) begin errors++; $display("[TB] FAIL divu_hi got %h want 1", h); end
        runOp(DIV, 32'h80000000, 32'hFFFFFFFF, 0, NONE, '0, 1'b0, cyc, h, l);
        modelOp(DIV, 32'h80000000, 32'hFFFFFFFF, ec);
        checks += 2;
        if (l !== 32'h80000000) begin errors++; $display("[TB] FAIL div_ovf_lo got %h want 80000000", l); end
        if (h !== 32'd0) begin errors++; $display("[TB] FAIL div_ovf_hi got %h want 0", h); end
    endtask

    task automatic test_mtlo_during_busy();
        int cyc, ec; logic [31:0] h, l;
        runOp(MULTU, 32'd7, 32'd9, 2, MTLO, 32'h1234, 1'b0, cyc, h, l);
        modelOp(MULTU, 32'd7, 32'd9, ec);
        checks += 3;
        if (cyc !== 5) begin errors++; $display("[TB] FAIL mtlo_busy got %0d want 5", cyc); end
        if (l !== 32'd63) begin errors++; $display("[TB] FAIL mtlo_ignored_lo got %h want 3f", l); end
        if (h !== 32'd0) begin errors++; $display("[TB] FAIL mtlo_ignored_hi got %h want 0", h); end
    endtask

    task automatic test_req();
        int cyc, ec; logic [31:0] h, l;
        foreach (hiM[i]) ;
        op = DIV; A = 32'd100; B = 32'd7; start = 1'b1; req = 1'b1;
        step();
        start = 1'b0; req = 1'b0; op = NONE;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL req_div_busy got %0b want 0", busy); end
        op = MTHI; A = 32'hCAFE0000; start = 1'b1; req = 1'b1;
        step();
        start = 1'b0; req = 1'b0;
        op = MFHI; #1;
        checks++;
        if (out !== hiM) begin errors++; $display("[TB] FAIL req_hi got %h want %h", out, hiM); end
        op = MFLO; #1;
        checks++;
        if (out !== loM) begin errors++; $display("[TB] FAIL req_lo got %h want %h", out, loM); end
        op = NONE;
        runOp(MULT, 32'd1000, 32'hFFFFFFFF, 2, DIV, 32'd5, 1'b1, cyc, h, l);
        modelOp(MULT, 32'd1000, 32'hFFFFFFFF, ec);
        checks += 3;
        if (cyc !== 5) begin errors++; $display("[TB] FAIL req_mult_busy got %0d want 5", cyc); end
        if (l !== 32'hFFFFFC18) begin errors++; $display("[TB] FAIL req_mult_lo got %h want fffffc18", l); end
        if (h !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL req_mult_hi got %h want ffffffff", h); end
    endtask

    task automatic test_mthi_divzero();
        int cyc, ec; logic [31:0] h, l;
        runOp(MTHI, 32'hDEADBEEF, 32'd0, 0, NONE, '0, 1'b0, cyc, h, l);
        modelOp(MTHI, 32'hDEADBEEF, 32'd0, ec);
        checks += 3;
        if (cyc !== 0) begin errors++; $display("[TB] FAIL mthi_busy got %0d want 0", cyc); end
        if (h !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL mthi_hi got %h want deadbeef", h); end
        if (l !== loM) begin errors++; $display("[TB] FAIL mthi_lo got %h want %h", l, loM); end
        op = MULT; #1;
        checks++;
        if (out !== 32'd0) begin errors++; $display("[TB] FAIL out_nonmf got %h want 0", out); end
        op = NONE;
        runOp(DIV, 32'd1234, 32'd0, 0, NONE, '0, 1'b0, cyc, h, l);
        modelOp(DIV, 32'd1234, 32'd0, ec);
        checks += 3;
        if (cyc !== 10) begin errors++; $display("[TB] FAIL divzero_busy got %0d want 10", cyc); end
        if (h !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL divzero_hi got %h want deadbeef", h); end
        if (l !== loM) begin errors++; $display("[TB] FAIL divzero_lo got %h want %h", l, loM); end
    endtask

    task automatic test_reset_mid();
        op = DIV; A = 32'd999; B = 32'd3; start = 1'b1; req = 1'b0;
        step();
        start = 1'b0; op = NONE;
        step(); step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        hiM = '0; loM = '0;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_busy got %0b want 0", busy); end
        for (int i = 0; i < 12; i++) begin
            op = MFHI; #1;
            checks++;
            if (out !== 32'd0) begin errors++; $display("[TB] FAIL rstmid_hi cyc=%0d got %h want 0", i, out); end
            op = MFLO; #1;
            checks++;
            if (out !== 32'd0) begin errors++; $display("[TB] FAIL rstmid_lo cyc=%0d got %h want 0", i, out); end
            op = NONE;
            step();
        end
    endtask

    // Consecutive random ops; each issues in the first idle cycle after the last.
    task automatic test_back_to_back();
        int cyc, ec; logic [3:0] o; logic [31:0] a, b, h, l;
        for (int n = 0; n < 40; n++) begin
            o = 4'($urandom_range(1, 6));
            a = $urandom();
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 16));
                2: b = 32'hFFFFFFFF;
                default: b = $urandom();
            endcase
            if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 300)) - 32'd150;
            runOp(o, a, b, 0, NONE, '0, 1'b0, cyc, h, l);
            modelOp(o, a, b, ec);
            checks += 3;
            if (cyc !== ec) begin errors++; $display("[TB] FAIL rand_busy op=%0d got %0d want %0d", o, cyc, ec); end
            if (h !== hiM) begin errors++; $display("[TB] FAIL rand_hi op=%0d a=%h b=%h got %h want %h", o, a, b, h, hiM); end
            if (l !== loM) begin errors++; $display("[TB] FAIL rand_lo op=%0d a=%h b=%h got %h want %h", o, a, b, l, loM); end
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_mtlo_during_busy();
        test_req();
        test_mthi_divzero();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
